// File: rtl/apagador_solicitudes_param.sv
// Request register and turn-off unit: latches cabin/hall calls per floor and clears the
// current floor's calls after HOLD door-open cycles. Define APAGADOR_DIR_FILTER_EN to clear hall calls by direction.
module apagador_solicitudes_param #(
    parameter int unsigned N_PISOS = 8,
    parameter int unsigned HOLD    = 4,
    parameter int unsigned PW      = $clog2(N_PISOS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_PISOS-1:0] cab_req,
    input  logic [N_PISOS-1:0] up_req,
    input  logic [N_PISOS-1:0] dn_req,
    input  logic [PW-1:0]      piso,
    input  logic               door_open,
    input  logic [1:0]         dir,
    output logic [N_PISOS-1:0] solic_cab,
    output logic [N_PISOS-1:0] solic_up,
    output logic [N_PISOS-1:0] solic_dn,
    output logic               served,
    output logic               any_pending
);

    localparam int unsigned        CW       = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0]      CNT_LAST = CW'(HOLD - 1);
    localparam logic [PW:0]        PISO_LIM = (PW+1)'(N_PISOS);
    // Top floor has no up button, ground floor has no down button.
    localparam logic [N_PISOS-1:0] UP_VALID = {1'b0, {(N_PISOS-1){1'b1}}};
    localparam logic [N_PISOS-1:0] DN_VALID = {{(N_PISOS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        S_IDLE,
        S_DWELL,
        S_SERVED
    } state_t;

    state_t              state;
    logic [PW-1:0]       piso_q;
    logic [CW-1:0]       cnt;
    logic                in_range;
    logic                same_floor;
    logic                clear_now;
    logic                kill_en;
    logic                hall_up_en;
    logic                hall_dn_en;
    logic [N_PISOS-1:0]  floor_sel;
    logic [N_PISOS-1:0]  kill_cab;
    logic [N_PISOS-1:0]  kill_up;
    logic [N_PISOS-1:0]  kill_dn;

    assign in_range   = ({1'b0, piso} < PISO_LIM);
    assign same_floor = (piso == piso_q);
    assign clear_now  = (state == S_DWELL) && door_open && same_floor && (cnt == CNT_LAST);
    assign kill_en    = clear_now || (state == S_SERVED);
    assign floor_sel  = N_PISOS'(1) << piso_q;

    // Hall-bit clear mask: both directions, or only the travel direction when filtered.
`ifdef APAGADOR_DIR_FILTER_EN
    always_comb begin
        hall_up_en = 1'b1;
        hall_dn_en = 1'b1;
        case (dir)
            2'b01:   hall_dn_en = 1'b0;
            2'b10:   hall_up_en = 1'b0;
            default: ;
        endcase
    end
`else
    logic dir_unused;
    assign dir_unused = ^dir;
    assign hall_up_en = 1'b1;
    assign hall_dn_en = 1'b1;
`endif

    assign kill_cab = kill_en ? floor_sel : '0;
    assign kill_up  = (kill_en && hall_up_en) ? floor_sel : '0;
    assign kill_dn  = (kill_en && hall_dn_en) ? floor_sel : '0;

    // Dwell FSM with registered served pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            piso_q <= '0;
            cnt    <= '0;
            served <= 1'b0;
        end else begin
            served <= clear_now;
            case (state)
                S_IDLE: begin
                    if (door_open && in_range) begin
                        piso_q <= piso;
                        cnt    <= '0;
                        state  <= S_DWELL;
                    end
                end
                S_DWELL: begin
                    if (!door_open || !same_floor) begin
                        state <= S_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_SERVED;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_SERVED: begin
                    if (!door_open || !same_floor) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Request registers: set by buttons, clear/absorb mask wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            solic_cab <= '0;
            solic_up  <= '0;
            solic_dn  <= '0;
        end else begin
            solic_cab <= (solic_cab | cab_req) & ~kill_cab;
            solic_up  <= (solic_up | (up_req & UP_VALID)) & ~kill_up;
            solic_dn  <= (solic_dn | (dn_req & DN_VALID)) & ~kill_dn;
        end
    end

    assign any_pending = (|solic_cab) | (|solic_up) | (|solic_dn);

endmodule
